// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave responder.
// Holds the FSM state encoding, byte width and default idle byte.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    localparam logic [SPI_BYTE_W-1:0] SPI_IDLE_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the synced level.
// Ports: clk, rst (async, active-high), din (async input), rise/fall (1-cycle strobes).
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/spi_slave_resp.sv
// SPI mode-0 slave: receives bytes from the master and returns queued tx bytes.
// Ports: clk_int/rst_int, spi_sck/ss_n/mosi in, spi_miso/miso_oe out,
// tx_data/tx_valid/tx_ready handshake, rx_data/rx_valid strobe, underrun, abort.
// Macro SPI_SLV_LSB_FIRST_EN: shift both directions LSB first (default MSB first).
module spi_slave_resp
    import spi_pkg::*;
#(
    parameter int                    SYNC_STAGES = 2,
    parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE   = SPI_IDLE_BYTE
) (
    input  logic                  clk_int,
    input  logic                  rst_int,
    input  logic                  spi_sck,
    input  logic                  spi_ss_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  underrun,
    output logic                  abort
);

    localparam int MSB = SPI_BYTE_W - 1;

    logic sck_rise, sck_fall;
    logic ss_rise, ss_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk  (clk_int),
        .rst  (rst_int),
        .din  (spi_sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
        .clk  (clk_int),
        .rst  (rst_int),
        .din  (spi_ss_n),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    // Same depth as sck so mosi stays aligned with the detected sck edge.
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   mosi_s;

    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) mosi_q <= '0;
        else         mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
    end

    assign mosi_s = mosi_q[SYNC_STAGES-1];

    spi_state_e            state;
    logic [2:0]            bit_cnt;
    logic                  byte_done;
    logic [SPI_BYTE_W-1:0] rx_shift;
    logic [SPI_BYTE_W-1:0] tx_shift;
    logic [SPI_BYTE_W-1:0] tx_buf;
    logic                  tx_full;

    logic [SPI_BYTE_W-1:0] rx_next;
    logic [SPI_BYTE_W-1:0] tx_next;
    logic                  tx_bit;

`ifdef SPI_SLV_LSB_FIRST_EN
    assign rx_next = {mosi_s, rx_shift[MSB:1]};
    assign tx_next = {1'b0, tx_shift[MSB:1]};
    assign tx_bit  = tx_shift[0];
`else
    assign rx_next = {rx_shift[MSB-1:0], mosi_s};
    assign tx_next = {tx_shift[MSB-1:0], 1'b0};
    assign tx_bit  = tx_shift[MSB];
`endif

    // A reload happens on entry to a frame and on the first falling
    // sck edge after a completed byte; slave-select release wins.
    logic load_now;
    logic tx_take;

    assign load_now = ~ss_rise &
                      ((state == LOAD) |
                       ((state == SHIFT) & sck_fall & byte_done));
    assign tx_take  = tx_valid & ~tx_full;
    assign tx_ready = ~tx_full;
    assign spi_miso = (state != IDLE) & tx_bit;

    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            byte_done   <= 1'b0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_shift    <= IDLE_BYTE;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            underrun    <= 1'b0;
            abort       <= 1'b0;
            spi_miso_oe <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            underrun <= 1'b0;
            abort    <= 1'b0;

            // Consume sees the pre-write buffer state.
            if (load_now) begin
                if (tx_full) begin
                    tx_shift <= tx_buf;
                    tx_full  <= 1'b0;
                end else begin
                    tx_shift <= IDLE_BYTE;
                    underrun <= 1'b1;
                end
            end

            if (tx_take) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end

            if (ss_rise && state != IDLE) begin
                state       <= IDLE;
                spi_miso_oe <= 1'b0;
                bit_cnt     <= 3'd0;
                byte_done   <= 1'b0;
                abort       <= (state == SHIFT) && (bit_cnt != 3'd0);
            end else begin
                unique case (state)
                    IDLE: begin
                        if (ss_fall) begin
                            state       <= LOAD;
                            spi_miso_oe <= 1'b1;
                        end
                    end
                    LOAD: begin
                        state     <= SHIFT;
                        bit_cnt   <= 3'd0;
                        byte_done <= 1'b0;
                    end
                    SHIFT: begin
                        if (sck_rise) begin
                            rx_shift <= rx_next;
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data   <= rx_next;
                                rx_valid  <= 1'b1;
                                byte_done <= 1'b1;
                            end
                        end else if (sck_fall) begin
                            if (byte_done) byte_done <= 1'b0;
                            else           tx_shift  <= tx_next;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        spi_miso_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_resp.sv
// Directed self-checking bench for spi_slave_resp (default build, MSB first).
// Drives SPI frames bit by bit and checks miso, rx bytes and status pulses.
module tb_spi_slave_resp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       underrun;
    logic       abort;

    spi_slave_resp dut (
        .clk_int     (clk),
        .rst_int     (rst),
        .spi_sck     (sck),
        .spi_ss_n    (ss_n),
        .spi_mosi    (mosi),
        .spi_miso    (miso),
        .spi_miso_oe (miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .underrun    (underrun),
        .abort       (abort)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail = 0;
    int         rx_cnt = 0;
    int         ur_cnt = 0;
    int         ab_cnt = 0;
    int         ur_snap = 0;
    logic [7:0] rx_hist [0:15];

    // Pulse counters sampled on the falling clock edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                rx_hist[rx_cnt % 16] = rx_data;
                rx_cnt++;
            end
            if (underrun) ur_cnt++;
            if (abort) ab_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_miso"}, 32'(miso), 32'd0);
        chk({tag, "_oe"}, 32'(miso_oe), 32'd0);
        chk({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
        chk({tag, "_rx_data"}, 32'(rx_data), 32'h00);
        chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        chk({tag, "_underrun"}, 32'(underrun), 32'd0);
        chk({tag, "_abort"}, 32'(abort), 32'd0);
    endtask

    // n mode-0 bits, MSB first; miso captured at each sck rise.
    task automatic spi_bits(input logic [7:0] b, input int n,
                            output logic [7:0] m);
        m = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            #40;
            sck = 1'b1;
            m = {m[6:0], miso};
            if (i == n - 1) ur_snap = ur_cnt;
            #40;
            sck = 1'b0;
        end
    endtask

    task automatic push(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        #10;
        tx_valid = 1'b0;
    endtask

    logic [7:0] m0, m1;
    int         r0, u0, a0;

    initial begin
        #50;
        chk_reset("reset");
        #50;
        rst = 1'b0;
        #100;

        // Queued A5 returned while master sends 3C.
        push(8'hA5);
        chk("f1_tx_full", 32'(tx_ready), 32'd0);
        r0 = rx_cnt;
        ss_n = 1'b0;
        #100;
        chk("f1_oe", 32'(miso_oe), 32'd1);
        spi_bits(8'h3C, 8, m0);
        chk("f1_miso", 32'(m0), 32'hA5);
        #40;
        ss_n = 1'b1;
        #100;
        chk("f1_rx_cnt", 32'(rx_cnt - r0), 32'd1);
        chk("f1_rx_data", 32'(rx_hist[r0 % 16]), 32'h3C);
        chk("f1_tx_empty", 32'(tx_ready), 32'd1);

        // Nothing queued: two idle bytes, two underruns.
        r0 = rx_cnt;
        u0 = ur_cnt;
        ss_n = 1'b0;
        #100;
        spi_bits(8'h01, 8, m0);
        spi_bits(8'h02, 8, m1);
        chk("f2_miso0", 32'(m0), 32'hFF);
        chk("f2_miso1", 32'(m1), 32'hFF);
        chk("f2_underruns", 32'(ur_snap - u0), 32'd2);
        #40;
        ss_n = 1'b1;
        #100;
        chk("f2_rx_cnt", 32'(rx_cnt - r0), 32'd2);
        chk("f2_rx0", 32'(rx_hist[r0 % 16]), 32'h01);
        chk("f2_rx1", 32'(rx_hist[(r0 + 1) % 16]), 32'h02);

        // Write lands in the LOAD cycle: idle byte first, data second.
        u0 = ur_cnt;
        ss_n = 1'b0;
        #30;
        chk("f3_oe_load", 32'(miso_oe), 32'd1);
        chk("f3_tx_ready", 32'(tx_ready), 32'd1);
        push(8'hC3);
        #60;
        spi_bits(8'h11, 8, m0);
        spi_bits(8'h22, 8, m1);
        chk("f3_miso0", 32'(m0), 32'hFF);
        chk("f3_miso1", 32'(m1), 32'hC3);
        chk("f3_underruns", 32'(ur_snap - u0), 32'd1);
        #40;
        ss_n = 1'b1;
        #100;

        // Abort after 5 bits; buffered 77 is kept.
        r0 = rx_cnt;
        a0 = ab_cnt;
        ss_n = 1'b0;
        #100;
        push(8'h77);
        chk("f4_tx_full", 32'(tx_ready), 32'd0);
        spi_bits(8'hAA, 5, m0);
        #40;
        ss_n = 1'b1;
        #40;
        chk("f4_oe_off", 32'(miso_oe), 32'd0);
        #100;
        chk("f4_abort", 32'(ab_cnt - a0), 32'd1);
        chk("f4_no_rx", 32'(rx_cnt - r0), 32'd0);
        chk("f4_tx_kept", 32'(tx_ready), 32'd0);

        // Retained byte goes out in the next frame.
        r0 = rx_cnt;
        ss_n = 1'b0;
        #100;
        spi_bits(8'h96, 8, m0);
        chk("f5_miso", 32'(m0), 32'h77);
        #40;
        ss_n = 1'b1;
        #100;
        chk("f5_rx_data", 32'(rx_hist[r0 % 16]), 32'h96);
        chk("f5_tx_ready", 32'(tx_ready), 32'd1);

        // Reset mid-byte.
        r0 = rx_cnt;
        a0 = ab_cnt;
        ss_n = 1'b0;
        #100;
        push(8'h3E);
        spi_bits(8'hF0, 3, m0);
        rst = 1'b1;
        ss_n = 1'b1;
        #10;
        chk_reset("midrst");
        #40;
        rst = 1'b0;
        #100;
        chk("rst_no_abort", 32'(ab_cnt - a0), 32'd0);
        chk("rst_no_rx", 32'(rx_cnt - r0), 32'd0);

        // Fresh frame after reset.
        r0 = rx_cnt;
        ss_n = 1'b0;
        #100;
        spi_bits(8'h5A, 8, m0);
        chk("f6_miso", 32'(m0), 32'hFF);
        #40;
        ss_n = 1'b1;
        #100;
        chk("f6_rx_cnt", 32'(rx_cnt - r0), 32'd1);
        chk("f6_rx_data", 32'(rx_hist[r0 % 16]), 32'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_resp.md
SPI_SLAVE_RESP -- requirements
Module: spi_slave_resp

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for sck/ss_n/mosi, legal range 2-3.
REQ-002 Parameter IDLE_BYTE, default 8'hFF: byte shifted out when no transmit data is queued.
REQ-003 clk_int  input  1  system clock; all logic single-clock on its rising edge; clk_int SHALL be >= 4x sck frequency.
REQ-004 rst_int  input  1  reset, asynchronous assert, active-high.
REQ-005 spi_sck  input  1  SPI clock from master, asynchronous to clk_int.
REQ-006 spi_ss_n  input  1  slave select, active-low.
REQ-007 spi_mosi  input  1  master-out data.
REQ-008 spi_miso  output  1  slave-out data.
REQ-009 spi_miso_oe  output  1  pad output enable for spi_miso.
REQ-010 tx_data  input  8  byte to return to master; tx_valid input 1; tx_ready output 1; valid/ready handshake.
REQ-011 rx_data  output  8  last complete received byte; rx_valid output 1, one-cycle strobe, no backpressure.
REQ-012 underrun  output  1  one-cycle pulse when IDLE_BYTE is substituted for missing tx data.
REQ-013 abort  output  1  one-cycle pulse when ss_n deasserts with a partial byte in flight.

Function
REQ-014 SPI mode 0 (CPOL=0, CPHA=0), 8-bit frames, MSB first unless REQ-031 applies.
REQ-015 sck, ss_n, mosi pass through SYNC_STAGES flops; edges detected by comparing synced value with one further delayed copy.
REQ-016 FSM states IDLE, LOAD, SHIFT: IDLE->LOAD on synced ss_n falling edge; LOAD->SHIFT after one cycle; SHIFT->IDLE on synced ss_n rising edge from any state.
REQ-017 In LOAD, the shift-out register takes the tx buffer if full (buffer emptied), else IDLE_BYTE with underrun pulsed; bit counter cleared to 0.
REQ-018 In SHIFT, on each synced sck rising edge, shift synced mosi into rx shifter and increment 3-bit bit counter (wraps 7->0).
REQ-019 On the rising edge where counter wraps 7->0, rx_data updates and rx_valid pulses for exactly one cycle, one cycle after edge detection.
REQ-020 On each synced sck falling edge in SHIFT, shift-out register advances one bit; on the falling edge after a byte completes, reload per REQ-017 rule instead of shifting.
REQ-021 spi_miso = current output bit of shift-out register while not IDLE; 0 in IDLE.
REQ-022 spi_miso_oe = 1 in LOAD and SHIFT, 0 in IDLE.
REQ-023 Tx buffer single entry; tx_ready = buffer empty; transfer when tx_valid & tx_ready.
REQ-024 Same-cycle write and consume: consume sees pre-write state (empty -> IDLE_BYTE, underrun); written byte is stored for the next byte.
REQ-025 ss_n rising edge with bit counter != 0: abort pulses, partial byte discarded, no rx_valid; the byte taken from the buffer is lost; tx buffer contents retained.
REQ-026 ss_n rising edge with bit counter == 0: no abort; return to IDLE.
REQ-027 sck edges while IDLE ignored.

Reset
REQ-028 rst_int asserted: FSM IDLE, all synchronizers to idle levels (sck 0, ss_n 1, mosi 0), counter 0, tx buffer empty.
REQ-029 Reset outputs: spi_miso 0, spi_miso_oe 0, tx_ready 1, rx_data 8'h00, rx_valid 0, underrun 0, abort 0.
REQ-030 Reset mid-frame: no abort or rx_valid pulse; on release, frame resumes only after a fresh ss_n falling edge.

Configuration
REQ-031 SPI_SLV_LSB_FIRST_EN defined: both shifters LSB first; rx_data bit order unchanged in meaning (bit0 = first received). Undefined: MSB first.

Structure
REQ-032 Shared package spi_pkg holds FSM state enum (IDLE, LOAD, SHIFT), SPI_BYTE_W = 8, default IDLE_BYTE constant.
REQ-033 One sub-module spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall detect, instantiated for sck and ss_n; mosi uses synchronizer only.

Verification
REQ-034 Queue 8'hA5, master sends 8'h3C in one frame -> miso bits 1,0,1,0,0,1,0,1; rx_data 8'h3C with single rx_valid.
REQ-035 No tx queued, 2-byte frame mosi 8'h01,8'h02 -> miso 8'hFF twice, two underrun pulses, rx_data 8'h01 then 8'h02.
REQ-036 ss_n deasserted after 5 sck pulses -> abort pulse, no rx_valid, miso_oe 0 within SYNC_STAGES+2 cycles.
REQ-037 tx_valid asserted in LOAD cycle with empty buffer -> byte 0 = IDLE_BYTE with underrun, byte 1 = written value.
REQ-038 rst_int pulsed mid-byte -> all outputs at REQ-029 values; next full frame 8'h5A received correctly.
